// File: rtl/fmq_cmd_pkg.sv
// Shared constants and types for the levitator-array UART command path.
// The array-side decoder imports the same b0 marker definition.
package fmq_cmd_pkg;

    localparam logic [1:0] CMD_OFFSET  = 2'b00;
    localparam logic [1:0] CMD_RELOAD  = 2'b01;
    localparam logic [1:0] CMD_QUERY   = 2'b10;
    localparam logic [1:0] CMD_DAC     = 2'b11;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ECHO    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam int         CMD_DATA_W  = 12;
    localparam int         B0_MARK_BIT = 7;
    localparam logic [7:0] B0_MARK     = 8'h01 << B0_MARK_BIT;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ECHO,
        ST_WAIT_RESP,
        ST_DONE
    } state_e;

    // Byte 0 is the first on the wire and sits in the top of the frame.
    function automatic logic [7:0] frame_byte(input logic [23:0] frame, input logic [1:0] idx);
        case (idx)
            2'd0:    return frame[23:16];
            2'd1:    return frame[15:8];
            default: return frame[7:0];
        endcase
    endfunction

endpackage

// File: rtl/fmq_cmd_tx_if.sv
// Command request, UART byte streams and completion status of the command initiator.
// slave is the initiator's own view; master is the host/UART side.
interface fmq_cmd_tx_if;
    import fmq_cmd_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_type;
    logic [6:0]            cmd_index;
    logic [CMD_DATA_W-1:0] cmd_data;

    logic [7:0]            tx_tdata;
    logic                  tx_tvalid;
    logic                  tx_tready;

    logic [7:0]            rx_tdata;
    logic                  rx_tvalid;
    logic                  rx_tready;

    logic                  done;
    logic [1:0]            err;
    logic [7:0]            resp_data;
    logic                  busy;

    modport slave (
        input  cmd_valid, cmd_type, cmd_index, cmd_data, tx_tready, rx_tdata, rx_tvalid,
        output cmd_ready, tx_tdata, tx_tvalid, rx_tready, done, err, resp_data, busy
    );

    modport master (
        output cmd_valid, cmd_type, cmd_index, cmd_data, tx_tready, rx_tdata, rx_tvalid,
        input  cmd_ready, tx_tdata, tx_tvalid, rx_tready, done, err, resp_data, busy
    );

endinterface

// File: rtl/fmq_cmd_encode.sv
// Combinational encoder from command fields to the 3-byte array frame ({b0, b1, b2}).
// Only b0 carries the marker bit so the array can resynchronise on it.
module fmq_cmd_encode
    import fmq_cmd_pkg::*;
#(
    parameter int OFFSET_WIDTH = 11
) (
    input  logic [1:0]            type_i,
    input  logic [6:0]            index_i,
    input  logic [OFFSET_WIDTH:0] data_i,
    output logic [23:0]           frame_o
);

    logic [7:0] b0, b1, b2;

    always_comb begin
        b0 = B0_MARK;
        b1 = '0;
        b2 = '0;
        case (type_i)
            CMD_OFFSET: begin
                b0 = B0_MARK | {3'b000, index_i[6:2]};
                b1 = {1'b0, index_i[1:0], data_i[OFFSET_WIDTH:OFFSET_WIDTH-4]};
                b2 = {1'b0, data_i[6:0]};
            end
            CMD_RELOAD: b0 = B0_MARK | 8'h20;
            CMD_QUERY:  b0 = B0_MARK | 8'h40;
            default: begin
                // data[8] picks divisor (1) or value (0); payload bit 7 rides alone in b1
                b0 = B0_MARK | {1'b0, 2'b11, data_i[8], 4'b0000};
                b1 = {7'b0, data_i[7]};
                b2 = {1'b0, data_i[6:0]};
            end
        endcase
    end

    assign frame_o = {b0, b1, b2};

endmodule

// File: rtl/fmq_cmd_tx.sv
// Host-side command initiator: latches one request as a 3-byte frame, sends it one byte
// at a time, checks every echo, captures a query reply and reports status with done/err.
module fmq_cmd_tx
    import fmq_cmd_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int OFFSET_WIDTH = 11,
    parameter int TIMEOUT      = 50000
) (
    input  logic        clk,
    input  logic        rst,
    fmq_cmd_tx_if.slave bus
);

    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_e                state_q;
    logic [23:0]           frame_d, frame_q;
    logic [1:0]            byte_idx_q;
    logic                  is_query_q;
    logic [TW-1:0]         timer_q;
    logic                  cmd_ready_q, tx_tvalid_q, rx_tready_q, done_q, busy_q;
    logic [DATA_WIDTH-1:0] tx_tdata_q, resp_data_q;
    logic [1:0]            err_q;

    fmq_cmd_encode #(.OFFSET_WIDTH(OFFSET_WIDTH)) u_encode (
        .type_i  (bus.cmd_type),
        .index_i (bus.cmd_index),
        .data_i  (bus.cmd_data),
        .frame_o (frame_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            frame_q     <= '0;
            byte_idx_q  <= '0;
            is_query_q  <= 1'b0;
            timer_q     <= '0;
            cmd_ready_q <= 1'b1;
            tx_tvalid_q <= 1'b0;
            tx_tdata_q  <= '0;
            rx_tready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= ERR_OK;
            resp_data_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // stray rx bytes are drained while idle
                    rx_tready_q <= 1'b1;
                    if (bus.cmd_valid) begin
                        frame_q     <= frame_d;
                        is_query_q  <= (bus.cmd_type == CMD_QUERY);
                        byte_idx_q  <= 2'd0;
                        tx_tdata_q  <= frame_byte(frame_d, 2'd0);
                        tx_tvalid_q <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        rx_tready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        err_q       <= ERR_OK;
                        resp_data_q <= '0;
                        state_q     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bus.tx_tready) begin
                        tx_tvalid_q <= 1'b0;
                        rx_tready_q <= 1'b1;
                        timer_q     <= '0;
                        state_q     <= ST_WAIT_ECHO;
                    end
                end
                ST_WAIT_ECHO: begin
                    // a byte on the expiry cycle takes priority over the timeout
                    if (bus.rx_tvalid) begin
                        timer_q <= '0;
                        if (bus.rx_tdata != tx_tdata_q) begin
                            err_q       <= ERR_ECHO;
                            done_q      <= 1'b1;
                            rx_tready_q <= 1'b0;
                            state_q     <= ST_DONE;
                        end else if (byte_idx_q != 2'd2) begin
                            byte_idx_q  <= byte_idx_q + 2'd1;
                            tx_tdata_q  <= frame_byte(frame_q, byte_idx_q + 2'd1);
                            tx_tvalid_q <= 1'b1;
                            rx_tready_q <= 1'b0;
                            state_q     <= ST_SEND;
                        end else if (is_query_q) begin
                            state_q     <= ST_WAIT_RESP;
                        end else begin
                            err_q       <= ERR_OK;
                            done_q      <= 1'b1;
                            rx_tready_q <= 1'b0;
                            state_q     <= ST_DONE;
                        end
                    end else if (timer_q == T_LAST) begin
                        err_q       <= ERR_TIMEOUT;
                        done_q      <= 1'b1;
                        rx_tready_q <= 1'b0;
                        state_q     <= ST_DONE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_WAIT_RESP: begin
                    if (bus.rx_tvalid) begin
                        resp_data_q <= bus.rx_tdata;
                        err_q       <= ERR_OK;
                        done_q      <= 1'b1;
                        rx_tready_q <= 1'b0;
                        state_q     <= ST_DONE;
                    end else if (timer_q == T_LAST) begin
                        err_q       <= ERR_TIMEOUT;
                        done_q      <= 1'b1;
                        rx_tready_q <= 1'b0;
                        state_q     <= ST_DONE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_DONE: begin
                    cmd_ready_q <= 1'b1;
                    rx_tready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    cmd_ready_q <= 1'b1;
                    tx_tvalid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.tx_tdata  = tx_tdata_q;
    assign bus.tx_tvalid = tx_tvalid_q;
    assign bus.rx_tready = rx_tready_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.resp_data = resp_data_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fmq_cmd_tx.sv
// Randomized bench for fmq_cmd_tx: loopback UART with stalls, echo corruption/withholding
// and a query responder, checked against a frame/status model built from the protocol rules.
module tb_fmq_cmd_tx;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fmq_cmd_tx_if bus();

    fmq_cmd_tx #(.DATA_WIDTH(8), .OFFSET_WIDTH(11), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Frame byte k of a command, straight from the wire-format rules.
    function automatic logic [7:0] ref_byte(input int ty, input int idx, input int dat, input int k);
        int b[3];
        case (ty)
            0: begin b[0] = 128 + idx / 4; b[1] = (idx % 4) * 32 + dat / 128; b[2] = dat % 128; end
            1: begin b[0] = 160; b[1] = 0; b[2] = 0; end
            2: begin b[0] = 192; b[1] = 0; b[2] = 0; end
            default: begin b[0] = 224 + ((dat / 256) % 2) * 16; b[1] = (dat / 128) % 2; b[2] = dat % 128; end
        endcase
        return 8'(b[k]);
    endfunction

    // One command end to end. bad_k: echo index returned corrupted; hold_k: echo index withheld.
    task automatic run_cmd(input int ty, input int idx, input int dat, input int stall, input int edly,
                           input int bad_k, input int hold_k, input int rval, input int rdly);
        int          exp_err, exp_sent, exp_rx;
        int          sent, stall_cnt, rx_cnt, pend_at, last_rx, hs_at, acc_at, done_at;
        bit          pend, pend_resp, held, got_done;
        logic [7:0]  pend_byte, held_byte;
        logic [31:0] err_v, resp_v;
        sent = 0; stall_cnt = 0; rx_cnt = 0; pend_at = 0; last_rx = 0; hs_at = 0; done_at = 0;
        pend = 0; pend_resp = 0; held = 0; got_done = 0;
        pend_byte = '0; held_byte = '0; err_v = '0; resp_v = '0;

        exp_err  = (bad_k >= 0) ? 1 : (hold_k >= 0) ? 2 : 0;
        exp_sent = (bad_k >= 0) ? bad_k + 1 : (hold_k >= 0) ? hold_k + 1 : 3;
        exp_rx   = (exp_err == 0 && ty == 2) ? 4 : (exp_err == 2) ? hold_k : exp_sent;

        chk("idle_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = 2'(ty);
        bus.cmd_index = 7'(idx);
        bus.cmd_data  = 12'(dat);
        step();
        acc_at = cyc;
        // inputs are scrambled after acceptance; the latched frame must not follow them
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = 2'($urandom);
        bus.cmd_index = 7'($urandom);
        bus.cmd_data  = 12'($urandom);
        chk("acc_busy", bus.busy, 1);
        chk("acc_ready", bus.cmd_ready, 0);
        chk("acc_txvalid", bus.tx_tvalid, 1);

        for (int t = 0; t < 300 && !got_done; t++) begin
            bus.tx_tready = 1'b0;
            bus.rx_tvalid = 1'b0;
            if (bus.tx_tvalid) begin
                chk("serial_tx", pend, 0);
                if (held) chk("tx_stable", bus.tx_tdata, held_byte);
                if (stall_cnt >= stall) begin
                    bus.tx_tready = 1'b1;
                    if (sent < 3) chk("tx_byte", bus.tx_tdata, ref_byte(ty, idx, dat, sent));
                    else          chk("tx_extra", sent, 2);
                    if (sent == bad_k) pend_byte = (bus.tx_tdata != 8'h00) ? 8'h00 : 8'hFF;
                    else               pend_byte = bus.tx_tdata;
                    pend      = (sent != hold_k);
                    pend_at   = cyc + 1 + edly;
                    hs_at     = cyc + 1;
                    sent++;
                    stall_cnt = 0;
                    held      = 0;
                end else begin
                    stall_cnt++;
                    held      = 1;
                    held_byte = bus.tx_tdata;
                end
            end else if (held) begin
                chk("tx_valid_held", bus.tx_tvalid, 1);
                held = 0;
            end
            if (pend && cyc >= pend_at) begin
                bus.rx_tvalid = 1'b1;
                bus.rx_tdata  = pend_byte;
                if (bus.rx_tready) begin
                    pend    = 0;
                    rx_cnt++;
                    last_rx = cyc;
                    if (!pend_resp && rx_cnt == 3 && ty == 2 && bad_k < 0) begin
                        pend      = 1;
                        pend_resp = 1;
                        pend_at   = cyc + 1 + rdly;
                        pend_byte = 8'(rval);
                    end
                end
            end
            step();
            if (bus.done) begin
                got_done = 1;
                done_at  = cyc;
                err_v    = 32'(bus.err);
                resp_v   = 32'(bus.resp_data);
            end
        end
        bus.tx_tready = 1'b0;
        bus.rx_tvalid = 1'b0;

        chk("done_seen", got_done, 1);
        chk("err", err_v, exp_err);
        chk("bytes_sent", sent, exp_sent);
        chk("rx_consumed", rx_cnt, exp_rx);
        if (exp_err == 2) chk("timeout_lat", done_at - hs_at, TO);
        else              chk("done_lat", done_at - last_rx, 1);
        if (exp_err == 0 && ty == 2) chk("resp_data", resp_v, rval);
        if (exp_err == 0 && stall == 0 && edly == 0 && rdly == 0)
            chk("min_lat", done_at - acc_at, (ty == 2) ? 7 : 6);
        step();
        chk("done_pulse", bus.done, 0);
        chk("back_ready", bus.cmd_ready, 1);
        chk("idle_rxready", bus.rx_tready, 1);
        chk("idle_busy", bus.busy, 0);
        chk("err_hold", bus.err, exp_err);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = '0;
        bus.cmd_index = '0;
        bus.cmd_data  = '0;
        bus.tx_tready = 1'b0;
        bus.rx_tdata  = '0;
        bus.rx_tvalid = 1'b0;

        #12;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_tx_tvalid", bus.tx_tvalid, 0);
        chk("rst_tx_tdata", bus.tx_tdata, 0);
        chk("rst_rx_tready", bus.rx_tready, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_resp", bus.resp_data, 0);
        chk("rst_busy", bus.busy, 0);
        #1 rst = 1'b1;
        step();
        chk("idle_rx_tready", bus.rx_tready, 1);

        run_cmd(0, 87, 'hABC, 0, 0, -1, -1, 0, 0);
        run_cmd(2, 5, 'h123, 0, 0, -1, -1, 88, 0);
        run_cmd(2, 9, 'h777, 2, 3, -1, -1, 'hC3, 4);
        run_cmd(3, 0, 'h1FF, 5, 0, -1, -1, 0, 0);
        run_cmd(0, 87, 'hABC, 0, 0, 1, -1, 0, 0);
        run_cmd(1, 0, 0, 0, 0, -1, 0, 0, 0);
        run_cmd(1, 0, 0, 0, TO - 1, -1, -1, 0, 0);

        // reset while a byte is offered and stalled: tx_tvalid must drop at once
        bus.cmd_valid = 1'b1; bus.cmd_type = 2'd0; bus.cmd_index = 7'd3; bus.cmd_data = 12'h456;
        step();
        bus.cmd_valid = 1'b0;
        step();
        chk("pre_rst_txvalid", bus.tx_tvalid, 1);
        #3 rst = 1'b0;
        #1;
        chk("rst_send_txvalid", bus.tx_tvalid, 0);
        chk("rst_send_busy", bus.busy, 0);
        chk("rst_send_rxready", bus.rx_tready, 0);
        #3 rst = 1'b1;
        step();

        // reset while waiting for an echo
        bus.cmd_valid = 1'b1; bus.cmd_type = 2'd3; bus.cmd_index = 7'd0; bus.cmd_data = 12'h0A5;
        step();
        bus.cmd_valid = 1'b0;
        bus.tx_tready = 1'b1;
        step();
        bus.tx_tready = 1'b0;
        step();
        chk("pre_rst_busy", bus.busy, 1);
        chk("pre_rst_rxready", bus.rx_tready, 1);
        #3 rst = 1'b0;
        #1;
        chk("rst_wait_busy", bus.busy, 0);
        chk("rst_wait_txvalid", bus.tx_tvalid, 0);
        chk("rst_wait_ready", bus.cmd_ready, 1);
        #3 rst = 1'b1;
        step();
        run_cmd(1, 0, 'hFFF, 0, 0, -1, -1, 0, 0);

        for (int i = 0; i < 16; i++) begin
            int ty, mode, k;
            ty   = int'($urandom_range(0, 3));
            mode = int'($urandom_range(0, 5));
            k    = int'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                chk("stray_rxready", bus.rx_tready, 1);
                bus.rx_tvalid = 1'b1;
                bus.rx_tdata  = 8'($urandom);
                step();
                bus.rx_tvalid = 1'b0;
            end
            run_cmd(ty, int'($urandom_range(0, 127)), int'($urandom_range(0, 4095)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
                    (mode == 0) ? k : -1, (mode == 1) ? k : -1,
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 6)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
